cross_bar_arbiter: RTL and testbench
====================================

Name: cross_bar_arbiter

Overview:
- Round-robin arbiter sharing one slave-side crossbar port between N_MASTERS requesters. All sides use the crossbar req/addr/cmd/wdata/ack/rdata handshake.
- Grants one master per transaction and registers its request fields onto the slave port.
- Returns the single-cycle ack and rdata to the granted master only.
- Sits between the master ports and a shared memory/peripheral slave.

Parameters:
- N_MASTERS, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, address width (matches crossbar package).
- DATA_WIDTH, 32, data width (matches crossbar package).
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m_req  in  N_MASTERS  per-master request.
- m_addr  in  N_MASTERS*ADDR_WIDTH  packed addresses; master i at slice i.
- m_cmd  in  N_MASTERS  per-master command: 0 = read, 1 = write.
- m_wdata  in  N_MASTERS*DATA_WIDTH  packed write data.
- m_ack  out  N_MASTERS  per-master ack, one-hot or zero.
- m_rdata  out  DATA_WIDTH  read data, valid when any m_ack bit is high.
- s_req  out  1  slave request.
- s_addr  out  ADDR_WIDTH  slave address.
- s_cmd  out  1  slave command.
- s_wdata  out  DATA_WIDTH  slave write data.
- s_ack  in  1  slave ack, single-cycle pulse.
- s_rdata  in  DATA_WIDTH  slave read data, valid with s_ack.
- grant_id  out  $clog2(N_MASTERS)  index of the current or last granted master.
- err  out  1  timeout pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset values (rst_n low, async): state = IDLE; s_req = 0; s_addr, s_wdata = 0; s_cmd = 0; grant_id = 0; err = 0; last pointer = N_MASTERS-1, so master 0 has first priority.
- Protocol: a master holds req, addr, cmd and wdata stable until it sees its ack. Each ack completes exactly one transaction.
- FSM IDLE:
  - If any m_req bit is high, pick the first set bit scanning from (last+1) mod N_MASTERS upward with wrap-around.
  - On the clock edge: register that master's addr, cmd and wdata onto the s_* outputs, set s_req = 1, set grant_id to its index, go to BUSY.
  - No requests: stay in IDLE with s_req = 0.
- FSM BUSY:
  - s_req and the s_* fields stay constant; new or changed m_req bits are ignored.
  - On s_ack = 1: m_ack[grant_id] = 1 combinationally in the same cycle; m_rdata = s_rdata.
  - Same edge: last <= grant_id, s_req <= 0, state <= IDLE.
- Latency:
  - Master req seen in IDLE at cycle t gives s_req high at t+1.
  - Slave ack at cycle k gives master ack at cycle k (0 cycles).
  - Next grant is issued at k+1 and its s_req rises at k+2, so there is a mandatory 1-cycle idle gap between transactions.
- m_ack = 0 in all cycles without s_ack in BUSY. s_ack seen in IDLE is ignored. m_rdata = s_rdata in all cycles; it is meaningful only with ack.
- A master dropping m_req while granted does not abort the transaction. Slave req stays asserted and the ack is still routed to that master.
- Fairness: a master holding req continuously waits at most N_MASTERS-1 other transactions.
- Reset mid-BUSY: everything returns to reset values immediately. Any outstanding slave ack after reset release is ignored because the FSM is in IDLE.

Optional Feature:
- Macro CROSS_BAR_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When the counter reaches TIMEOUT_CYCLES, in that cycle: m_ack[grant_id] = 1, m_rdata = 32'hDEAD_BEEF (truncated or zero-extended to DATA_WIDTH), err = 1.
  - Same edge: s_req <= 0, go to IDLE, advance last.
  - s_ack in the same cycle wins: normal completion, no err.
- Undefined: no counter; BUSY waits indefinitely; err tied 0.

Test Plan:
- Single read: master 2 reads addr 0x100 with cmd 0; slave acks 3 cycles after s_req with rdata 0x1234_5678 -> s_addr = 0x100 at t+1; m_ack = 4'b0100 with m_rdata = 0x1234_5678 in the ack cycle; s_req low next cycle.
- Round-robin: all 4 masters hold req from reset; slave acks each request after 1 cycle -> grant order 0,1,2,3,0; exactly one m_ack bit per transaction; 1 idle cycle between s_req pulses.
- Field isolation: master 1 writes 0xA5A5_A5A5 to 0x20 while master 3 changes its addr every cycle -> s_addr/s_wdata stay 0x20/0xA5A5_A5A5 throughout BUSY; m_ack[3] never high during that transaction.
- Reset mid-op: rst_n low 2 cycles into BUSY for master 1, then s_ack pulses after release -> all outputs 0; no m_ack; next grant goes to master 0.
- Abandoned req: master 0 drops m_req 1 cycle after grant -> s_req held until s_ack; m_ack[0] pulses; arbitration continues normally.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): slave never acks -> on the 16th BUSY cycle m_ack[grant_id] = 1, m_rdata = 0xDEAD_BEEF, err = 1 for one cycle, s_req low next cycle.

Source files
------------

// File: rtl/cross_bar_arbiter.sv
// Round-robin arbiter that shares one crossbar slave port between N_MASTERS requesters.
// Optional watchdog timeout is enabled by defining CROSS_BAR_ARBITER_TIMEOUT_EN.
module cross_bar_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_MASTERS-1:0]             m_req,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS-1:0]             m_cmd,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  output logic [N_MASTERS-1:0]             m_ack,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             s_req,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic                             s_cmd,
  output logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic                             s_ack,
  input  logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [$clog2(N_MASTERS)-1:0]     grant_id,
  output logic                             err
);

  localparam int GW = $clog2(N_MASTERS);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam logic [GW-1:0] LAST_INIT = GW'(N_MASTERS - 1);

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cross_bar_arbiter: unsupported parameter values");
  end

  logic            state;
  logic [GW-1:0]   last_ptr;
  logic            any_req;
  logic            upper_found;
  logic [GW-1:0]   upper_pick;
  logic [GW-1:0]   wrap_pick;
  logic [GW-1:0]   pick;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic            sel_cmd;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic            wd_hit;
  logic            done;

  assign any_req = |m_req;

  // Round-robin pick: lowest requester above last_ptr, else lowest requester overall (wrap).
  always_comb begin
    upper_found = 1'b0;
    upper_pick  = '0;
    wrap_pick   = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_req[i]) begin
        wrap_pick = i[GW-1:0];
        if (i > int'(last_ptr)) begin
          upper_found = 1'b1;
          upper_pick  = i[GW-1:0];
        end
      end
    end
    pick = upper_found ? upper_pick : wrap_pick;
  end

  always_comb begin
    sel_addr  = '0;
    sel_cmd   = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (i[GW-1:0] == pick) begin
        sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_cmd   = m_cmd[i];
        sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef CROSS_BAR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  logic [CW-1:0] wd_cnt;

  // wd_cnt counts completed BUSY cycles, so a value of TIMEOUT_CYCLES-1 marks the final allowed cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else if (!s_ack) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  assign wd_hit  = (state == BUSY) && !s_ack && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err     = wd_hit;
  assign m_rdata = wd_hit ? TIMEOUT_DATA : s_rdata;
`else
  assign wd_hit  = 1'b0;
  assign err     = 1'b0;
  assign m_rdata = s_rdata;
`endif

  assign done = (state == BUSY) && (s_ack || wd_hit);

  always_comb begin
    m_ack = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      m_ack[i] = done && (i[GW-1:0] == grant_id);
    end
  end

  // Slave fields are captured once at grant and held for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_req    <= 1'b0;
      s_addr   <= '0;
      s_cmd    <= 1'b0;
      s_wdata  <= '0;
      grant_id <= '0;
      last_ptr <= LAST_INIT;
    end else if (state == IDLE) begin
      if (any_req) begin
        s_req    <= 1'b1;
        s_addr   <= sel_addr;
        s_cmd    <= sel_cmd;
        s_wdata  <= sel_wdata;
        grant_id <= pick;
        state    <= BUSY;
      end
    end else begin
      if (done) begin
        last_ptr <= grant_id;
        s_req    <= 1'b0;
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Testbench for cross_bar_arbiter: directed vectors with a queue-based scoreboard
// checking slave-side grants and master-side acks.
module tb_cross_bar_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      m_req;
  logic [N*AW-1:0]   m_addr;
  logic [N-1:0]      m_cmd;
  logic [N*DW-1:0]   m_wdata;
  logic [N-1:0]      m_ack;
  logic [DW-1:0]     m_rdata;
  logic              s_req;
  logic [AW-1:0]     s_addr;
  logic              s_cmd;
  logic [DW-1:0]     s_wdata;
  logic              s_ack;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        grant_id;
  logic              err;

  typedef struct {
    logic [AW-1:0] addr;
    logic          cmd;
    logic [DW-1:0] wdata;
    logic [1:0]    gid;
  } slave_exp_t;

  typedef struct {
    logic [N-1:0]  ack;
    logic [DW-1:0] rdata;
  } ack_exp_t;

  slave_exp_t slave_q[$];
  ack_exp_t   ack_q[$];
  int         checks = 0;
  int         passed = 0;
  logic       s_req_prev = 1'b0;

  cross_bar_arbiter #(
    .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .grant_id(grant_id), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic ack, input logic [DW-1:0] rdata);
    m_req   = req;
    s_ack   = ack;
    s_rdata = rdata;
  endtask

  task automatic setMaster(input int i, input logic [AW-1:0] addr, input logic cmd, input logic [DW-1:0] wdata);
    m_addr[i*AW +: AW]  = addr;
    m_cmd[i]            = cmd;
    m_wdata[i*DW +: DW] = wdata;
  endtask

  task automatic expectGrant(input int i);
    slave_exp_t e;
    e.addr  = m_addr[i*AW +: AW];
    e.cmd   = m_cmd[i];
    e.wdata = m_wdata[i*DW +: DW];
    e.gid   = 2'(i);
    slave_q.push_back(e);
  endtask

  task automatic expectAck(input logic [N-1:0] a, input logic [DW-1:0] d);
    ack_exp_t e;
    e.ack   = a;
    e.rdata = d;
    ack_q.push_back(e);
  endtask

  // Monitor: every s_req rising edge and every m_ack pulse consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    slave_exp_t se;
    ack_exp_t   ae;
    if (rst_n) begin
      if (s_req && !s_req_prev) begin
        if (slave_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_sreq: got s_addr=%0h gid=%0d, nothing queued", s_addr, grant_id);
        end else begin
          se = slave_q.pop_front();
          checkOutput("s_addr", 64'(s_addr), 64'(se.addr));
          checkOutput("s_cmd", 64'(s_cmd), 64'(se.cmd));
          checkOutput("s_wdata", 64'(s_wdata), 64'(se.wdata));
          checkOutput("grant_id", 64'(grant_id), 64'(se.gid));
        end
      end
      if (m_ack != '0) begin
        if (ack_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_ack: got m_ack=%b, nothing queued", m_ack);
        end else begin
          ae = ack_q.pop_front();
          checkOutput("m_ack", 64'(m_ack), 64'(ae.ack));
          checkOutput("m_rdata", 64'(m_rdata), 64'(ae.rdata));
        end
      end
    end
    s_req_prev = s_req;
  end

  initial begin
    rst_n = 1'b0;
    m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    tick(); tick();
    checkOutput("rst_sreq", 64'(s_req), 64'd0);
    checkOutput("rst_saddr", 64'(s_addr), 64'd0);
    checkOutput("rst_swdata", 64'(s_wdata), 64'd0);
    checkOutput("rst_scmd", 64'(s_cmd), 64'd0);
    checkOutput("rst_gid", 64'(grant_id), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_mack", 64'(m_ack), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single read by master 2, slave acks 3 cycles after s_req.
    setMaster(2, 32'h100, 1'b0, 32'h0);
    expectGrant(2);
    applyStimulus(4'b0100, 1'b0, '0);
    tick();
    checkOutput("t1_sreq", 64'(s_req), 64'd1);
    checkOutput("t1_saddr", 64'(s_addr), 64'h100);
    tick(); tick(); tick();
    expectAck(4'b0100, 32'h1234_5678);
    applyStimulus(4'b0100, 1'b1, 32'h1234_5678);
    #1;
    checkOutput("t1_mack", 64'(m_ack), 64'b0100);
    tick();
    applyStimulus('0, 1'b0, '0);
    checkOutput("t1_sreq_low", 64'(s_req), 64'd0);
    checkOutput("t1_gid", 64'(grant_id), 64'd2);
    tick();

    // Round-robin from reset with all four masters holding req.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) setMaster(i, 32'h1000 + 32'(i) * 32'h10, i[0], 32'hC0DE_0000 + 32'(i));
    tick();
    rst_n = 1'b1;
    expectGrant(0); expectGrant(1); expectGrant(2); expectGrant(3); expectGrant(0);
    applyStimulus(4'hF, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rr_sreq", 64'(s_req), 64'd1);
      tick();
      expectAck(4'(1 << (k % 4)), 32'h5000 + 32'(k));
      applyStimulus(4'hF, 1'b1, 32'h5000 + 32'(k));
      tick();
      applyStimulus((k == 4) ? 4'h0 : 4'hF, 1'b0, '0);
      checkOutput("rr_gap", 64'(s_req), 64'd0);
    end
    tick();

    // Field isolation: master 3 wiggles its address while master 1 is served.
    setMaster(1, 32'h20, 1'b1, 32'hA5A5_A5A5);
    setMaster(3, 32'h3000, 1'b0, 32'h33);
    expectGrant(1);
    applyStimulus(4'b1010, 1'b0, '0);
    tick();
    for (int k = 0; k < 4; k++) begin
      setMaster(3, 32'h3000 + 32'(k + 1) * 32'h4, 1'b0, 32'h33);
      #1;
      checkOutput("iso_saddr", 64'(s_addr), 64'h20);
      checkOutput("iso_swdata", 64'(s_wdata), 64'hA5A5_A5A5);
      checkOutput("iso_mack3", 64'(m_ack[3]), 64'd0);
      tick();
    end
    expectAck(4'b0010, 32'h7777);
    applyStimulus(4'b1010, 1'b1, 32'h7777);
    tick();
    applyStimulus(4'b1000, 1'b0, '0);
    expectGrant(3);
    tick();
    tick();
    expectAck(4'b1000, 32'h3333);
    applyStimulus(4'b1000, 1'b1, 32'h3333);
    tick();
    applyStimulus('0, 1'b0, '0);
    tick();

    // Reset two cycles into BUSY; a stale slave ack afterwards must be ignored.
    expectGrant(1);
    applyStimulus(4'b0010, 1'b0, '0);
    tick();
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sreq", 64'(s_req), 64'd0);
    checkOutput("mid_rst_saddr", 64'(s_addr), 64'd0);
    checkOutput("mid_rst_swdata", 64'(s_wdata), 64'd0);
    checkOutput("mid_rst_gid", 64'(grant_id), 64'd0);
    checkOutput("mid_rst_mack", 64'(m_ack), 64'd0);
    applyStimulus('0, 1'b0, '0);
    tick(); tick();
    rst_n = 1'b1;
    applyStimulus('0, 1'b1, 32'hBAD0_BAD0);
    #1;
    checkOutput("stale_ack_mack", 64'(m_ack), 64'd0);
    tick();
    applyStimulus(4'b0011, 1'b0, '0);
    expectGrant(0);
    tick();
    checkOutput("post_rst_gid", 64'(grant_id), 64'd0);
    tick();
    expectAck(4'b0001, 32'h4444);
    applyStimulus(4'b0011, 1'b1, 32'h4444);
    tick();
    applyStimulus('0, 1'b0, '0);
    tick();

    // Master 0 abandons its request one cycle after grant.
    expectGrant(0);
    applyStimulus(4'b0001, 1'b0, '0);
    tick();
    tick();
    applyStimulus('0, 1'b0, '0);
    tick();
    checkOutput("abn_sreq", 64'(s_req), 64'd1);
    checkOutput("abn_gid", 64'(grant_id), 64'd0);
    tick();
    expectAck(4'b0001, 32'hBEEF_0000);
    applyStimulus('0, 1'b1, 32'hBEEF_0000);
    tick();
    applyStimulus(4'b0101, 1'b0, '0);
    checkOutput("abn_sreq_low", 64'(s_req), 64'd0);
    expectGrant(2);
    tick();
    checkOutput("abn_next_gid", 64'(grant_id), 64'd2);
    tick();
    expectAck(4'b0100, 32'h6666);
    applyStimulus(4'b0101, 1'b1, 32'h6666);
    tick();
    applyStimulus('0, 1'b0, '0);
    tick();

    // Stalled slave: watchdog completion when enabled, otherwise indefinite wait.
    expectGrant(3);
    applyStimulus(4'b1000, 1'b0, '0);
    tick();
`ifdef CROSS_BAR_ARBITER_TIMEOUT_EN
    for (int k = 0; k < 14; k++) begin
      checkOutput("to_err_early", 64'(err), 64'd0);
      tick();
    end
    expectAck(4'b1000, 32'hDEAD_BEEF);
    tick();
    checkOutput("to_err", 64'(err), 64'd1);
    checkOutput("to_mack", 64'(m_ack), 64'b1000);
    tick();
    applyStimulus('0, 1'b0, '0);
    checkOutput("to_sreq_low", 64'(s_req), 64'd0);
    checkOutput("to_err_low", 64'(err), 64'd0);
`else
    for (int k = 0; k < 20; k++) begin
      checkOutput("stall_err", 64'(err), 64'd0);
      tick();
    end
    checkOutput("stall_sreq", 64'(s_req), 64'd1);
    expectAck(4'b1000, 32'h7E57);
    applyStimulus(4'b1000, 1'b1, 32'h7E57);
    #1;
    checkOutput("stall_ack_err", 64'(err), 64'd0);
    tick();
    applyStimulus('0, 1'b0, '0);
    checkOutput("stall_sreq_low", 64'(s_req), 64'd0);
`endif
    tick(); tick();

    checkOutput("sb_slave_empty", 64'(slave_q.size()), 64'd0);
    checkOutput("sb_ack_empty", 64'(ack_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
